// File: rtl/transpad_sched.sv
// Round-robin scheduler sharing the transpad translation engine among NREQ requesters.
// Grants a session, pulses the CU start, supervises abort/watchdog stop and reports completion.
module transpad_sched #(
  parameter int NREQ    = 4,
  parameter int TMO_W   = 16,
  parameter int TMO_CYC = 4096
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NREQ-1:0]          req,
  input  logic                     cu_idle,
  output logic [NREQ-1:0]          gnt,
  output logic [$clog2(NREQ)-1:0]  conf_sel,
  output logic                     start_req_ok,
  output logic                     stop_req,
  output logic [NREQ-1:0]          done,
  output logic                     tmo
);

  localparam int IDX_W = $clog2(NREQ);
  // A limit that does not fit the counter can never be reached, so it disables the watchdog.
  localparam bit TMO_EN = (TMO_CYC > 0) && ((TMO_CYC >> TMO_W) == 0);
  localparam logic [TMO_W-1:0] TMO_VAL = TMO_W'(TMO_CYC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_RUN,
    S_STOP,
    S_RELEASE
  } state_t;

  state_t              state_reg;
  logic [IDX_W-1:0]    owner_reg;
  logic [IDX_W-1:0]    last_reg;
  logic                tmo_flag_reg;
  logic [TMO_W-1:0]    wd_reg;
  logic [NREQ-1:0]     gnt_reg;
  logic                start_reg;
  logic                stop_reg;
  logic [NREQ-1:0]     done_reg;
  logic                tmo_reg;

  logic [NREQ-1:0]     elig;
  logic                pick_valid;
  logic [IDX_W-1:0]    pick_idx;
  logic [TMO_W-1:0]    wd_inc;

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int ofs);
    int sum;
    sum = int'(base) + ofs;
    if (sum >= NREQ) sum = sum - NREQ;
    return IDX_W'(sum);
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NREQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

  // A requester being told it is done cannot win in that same cycle.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_elig
      assign elig[gi] = req[gi] & ~done_reg[gi];
    end
  endgenerate

  // Scan downward so the nearest candidate after last_reg is assigned last and wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (elig[wrap_idx(last_reg, k)]) begin
        pick_valid = 1'b1;
        pick_idx   = wrap_idx(last_reg, k);
      end
    end
  end

  // Watchdog value including the current RUN cycle, saturating at all-ones.
  assign wd_inc = (wd_reg == '1) ? wd_reg : wd_reg + TMO_W'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg    <= S_IDLE;
      owner_reg    <= '0;
      last_reg     <= IDX_W'(NREQ - 1);
      tmo_flag_reg <= 1'b0;
      wd_reg       <= '0;
      gnt_reg      <= '0;
      start_reg    <= 1'b0;
      stop_reg     <= 1'b0;
      done_reg     <= '0;
      tmo_reg      <= 1'b0;
    end else begin
      start_reg <= 1'b0;
      done_reg  <= '0;
      tmo_reg   <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (cu_idle && pick_valid) begin
            owner_reg <= pick_idx;
            gnt_reg   <= onehot(pick_idx);
            start_reg <= 1'b1;
            wd_reg    <= '0;
            state_reg <= S_GRANT;
          end
        end
        S_GRANT: begin
          wd_reg    <= '0;
          state_reg <= S_RUN;
        end
        S_RUN: begin
          wd_reg <= wd_inc;
          // Completion outranks abort and timeout, so a finished session never reports tmo.
          if (cu_idle) begin
            gnt_reg   <= '0;
            done_reg  <= onehot(owner_reg);
            tmo_reg   <= tmo_flag_reg;
            state_reg <= S_RELEASE;
          end else if (!req[owner_reg]) begin
            stop_reg  <= 1'b1;
            state_reg <= S_STOP;
          end else if (TMO_EN && (wd_inc == TMO_VAL)) begin
            tmo_flag_reg <= 1'b1;
            stop_reg     <= 1'b1;
            state_reg    <= S_STOP;
          end
        end
        S_STOP: begin
          if (cu_idle) begin
            gnt_reg   <= '0;
            stop_reg  <= 1'b0;
            done_reg  <= onehot(owner_reg);
            tmo_reg   <= tmo_flag_reg;
            state_reg <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          last_reg     <= owner_reg;
          tmo_flag_reg <= 1'b0;
          state_reg    <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign gnt          = gnt_reg;
  assign conf_sel     = owner_reg;
  assign start_req_ok = start_reg;
  assign stop_req     = stop_reg;
  assign done         = done_reg;
  assign tmo          = tmo_reg;

endmodule

// File: tb/tb_transpad_sched.sv
// Directed bench for transpad_sched: per-cycle vector table on a default instance,
// plus hand-written watchdog, coincidence and asynchronous reset sequences.
module tb_transpad_sched;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;

  logic [3:0] req_a = '0;
  logic       cu_a = 1'b1;
  logic [3:0] gnt_a, done_a;
  logic [1:0] sel_a;
  logic       start_a, stop_a, tmo_a;

  logic [3:0] req_b = '0;
  logic       cu_b = 1'b1;
  logic [3:0] gnt_b, done_b, gnt_c, done_c;
  logic [1:0] sel_b, sel_c;
  logic       start_b, stop_b, tmo_b, start_c, stop_c, tmo_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  transpad_sched #(.NREQ(4), .TMO_W(16), .TMO_CYC(4096)) u_dut_a (
    .clk(clk), .rstn(rstn), .req(req_a), .cu_idle(cu_a),
    .gnt(gnt_a), .conf_sel(sel_a), .start_req_ok(start_a),
    .stop_req(stop_a), .done(done_a), .tmo(tmo_a)
  );

  transpad_sched #(.NREQ(4), .TMO_W(16), .TMO_CYC(8)) u_dut_b (
    .clk(clk), .rstn(rstn), .req(req_b), .cu_idle(cu_b),
    .gnt(gnt_b), .conf_sel(sel_b), .start_req_ok(start_b),
    .stop_req(stop_b), .done(done_b), .tmo(tmo_b)
  );

  transpad_sched #(.NREQ(4), .TMO_W(4), .TMO_CYC(0)) u_dut_c (
    .clk(clk), .rstn(rstn), .req(req_b), .cu_idle(cu_b),
    .gnt(gnt_c), .conf_sel(sel_c), .start_req_ok(start_c),
    .stop_req(stop_c), .done(done_c), .tmo(tmo_c)
  );

  typedef struct {
    logic       rstn;
    logic [3:0] req;
    logic       cu;
    logic [3:0] gnt;
    logic       st;
    logic       sp;
    logic [3:0] dn;
    logic       tm;
    logic [1:0] sel;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic v(input logic rs, input logic [3:0] rq, input logic cu, input logic [3:0] g,
                   input logic st, input logic sp, input logic [3:0] dn, input logic tm,
                   input logic [1:0] sel);
    vec_t e;
    e.rstn = rs; e.req = rq; e.cu = cu; e.gnt = g; e.st = st;
    e.sp = sp; e.dn = dn; e.tm = tm; e.sel = sel;
    tbl.push_back(e);
  endtask

  // One full session: GRANT, RUN1 (CU still idle during GRANT), nlow busy cycles, RELEASE, IDLE.
  task automatic sess(input logic [1:0] o, input logic [3:0] rq, input int nlow);
    logic [3:0] oh;
    oh = 4'b0001 << o;
    v(1, rq, 1, oh,      1, 0, 4'b0000, 0, o);
    v(1, rq, 1, oh,      0, 0, 4'b0000, 0, o);
    for (int i = 0; i < nlow; i++) v(1, rq, 0, oh, 0, 0, 4'b0000, 0, o);
    v(1, rq, 1, 4'b0000, 0, 0, oh,      0, o);
    v(1, rq, 1, 4'b0000, 0, 0, 4'b0000, 0, o);
  endtask

  initial begin : main
    logic seen;

    // Single request with a 20-cycle session.
    v(0, 4'b0000, 1, 4'b0000, 0, 0, 4'b0000, 0, 2'd0);
    v(1, 4'b0000, 1, 4'b0000, 0, 0, 4'b0000, 0, 2'd0);
    sess(2'd0, 4'b0001, 19);
    v(1, 4'b0000, 1, 4'b0000, 0, 0, 4'b0000, 0, 2'd0);

    // Contention with 1011 held: rotation 0,1,3,0,1,3.
    v(0, 4'b0000, 1, 4'b0000, 0, 0, 4'b0000, 0, 2'd0);
    v(1, 4'b0000, 1, 4'b0000, 0, 0, 4'b0000, 0, 2'd0);
    sess(2'd0, 4'b1011, 4);
    sess(2'd1, 4'b1011, 4);
    sess(2'd3, 4'b1011, 4);
    sess(2'd0, 4'b1011, 4);
    sess(2'd1, 4'b1011, 4);
    sess(2'd3, 4'b1011, 4);
    v(1, 4'b0000, 1, 4'b0000, 0, 0, 4'b0000, 0, 2'd3);

    // Abort by owner 2, re-raise during STOP, then requester 3 served.
    v(0, 4'b0000, 1, 4'b0000, 0, 0, 4'b0000, 0, 2'd0);
    v(1, 4'b0000, 1, 4'b0000, 0, 0, 4'b0000, 0, 2'd0);
    v(1, 4'b1100, 1, 4'b0100, 1, 0, 4'b0000, 0, 2'd2);
    v(1, 4'b1100, 1, 4'b0100, 0, 0, 4'b0000, 0, 2'd2);
    v(1, 4'b1100, 0, 4'b0100, 0, 0, 4'b0000, 0, 2'd2);
    v(1, 4'b1100, 0, 4'b0100, 0, 0, 4'b0000, 0, 2'd2);
    v(1, 4'b1100, 0, 4'b0100, 0, 0, 4'b0000, 0, 2'd2);
    v(1, 4'b1000, 0, 4'b0100, 0, 1, 4'b0000, 0, 2'd2);
    v(1, 4'b1100, 0, 4'b0100, 0, 1, 4'b0000, 0, 2'd2);
    v(1, 4'b1000, 0, 4'b0100, 0, 1, 4'b0000, 0, 2'd2);
    v(1, 4'b1000, 1, 4'b0000, 0, 0, 4'b0100, 0, 2'd2);
    v(1, 4'b1000, 1, 4'b0000, 0, 0, 4'b0000, 0, 2'd2);
    v(1, 4'b1000, 1, 4'b1000, 1, 0, 4'b0000, 0, 2'd3);
    v(1, 4'b1000, 1, 4'b1000, 0, 0, 4'b0000, 0, 2'd3);

    // Owner 0 re-requests during its done cycle while 2 is pending: 2 goes first.
    v(0, 4'b0000, 1, 4'b0000, 0, 0, 4'b0000, 0, 2'd0);
    v(1, 4'b0000, 1, 4'b0000, 0, 0, 4'b0000, 0, 2'd0);
    v(1, 4'b0001, 1, 4'b0001, 1, 0, 4'b0000, 0, 2'd0);
    v(1, 4'b0001, 1, 4'b0001, 0, 0, 4'b0000, 0, 2'd0);
    v(1, 4'b0001, 0, 4'b0001, 0, 0, 4'b0000, 0, 2'd0);
    v(1, 4'b0101, 1, 4'b0000, 0, 0, 4'b0001, 0, 2'd0);
    v(1, 4'b0101, 1, 4'b0000, 0, 0, 4'b0000, 0, 2'd0);
    v(1, 4'b0101, 1, 4'b0100, 1, 0, 4'b0000, 0, 2'd2);
    v(1, 4'b0101, 1, 4'b0100, 0, 0, 4'b0000, 0, 2'd2);

    foreach (tbl[i]) begin
      rstn  = tbl[i].rstn;
      req_a = tbl[i].req;
      cu_a  = tbl[i].cu;
      @(posedge clk); #1;
      $display("step %0d rstn=%b req=%b cu_idle=%b gnt=%b start=%b stop=%b done=%b tmo=%b sel=%0d",
               i, tbl[i].rstn, tbl[i].req, tbl[i].cu, gnt_a, start_a, stop_a, done_a, tmo_a, sel_a);
      check($sformatf("step%0d gnt", i),   gnt_a,   tbl[i].gnt);
      check($sformatf("step%0d start", i), start_a, tbl[i].st);
      check($sformatf("step%0d stop", i),  stop_a,  tbl[i].sp);
      check($sformatf("step%0d done", i),  done_a,  tbl[i].dn);
      check($sformatf("step%0d tmo", i),   tmo_a,   tbl[i].tm);
      check($sformatf("step%0d sel", i),   sel_a,   tbl[i].sel);
    end

    // Owner 2 drops req -> STOP, then asynchronous reset mid-cycle clears everything.
    req_a = 4'b0001; cu_a = 1'b0;
    @(posedge clk); #1;
    $display("abort2 stop=%b gnt=%b", stop_a, gnt_a);
    check("abort2 stop", stop_a, 1'b1);
    check("abort2 gnt", gnt_a, 4'b0100);
    #3 rstn = 1'b0;
    #1;
    $display("async reset gnt=%b stop=%b sel=%0d", gnt_a, stop_a, sel_a);
    check("async gnt", gnt_a, 4'b0000);
    check("async stop", stop_a, 1'b0);
    check("async sel", sel_a, 2'd0);
    check("async start/done/tmo", {start_a, done_a, tmo_a}, 6'b0);
    @(posedge clk); #1;
    rstn = 1'b1; req_a = 4'b1111; cu_a = 1'b1;
    @(posedge clk); #1;
    $display("post reset grant gnt=%b start=%b sel=%0d", gnt_a, start_a, sel_a);
    check("post reset gnt", gnt_a, 4'b0001);
    check("post reset start", start_a, 1'b1);

    // Watchdog: B (limit 8) stops after 8 RUN cycles; C (disabled) never stops.
    req_b = 4'b0001; cu_b = 1'b1;
    @(posedge clk); #1;
    $display("tmo grant start_b=%b start_c=%b", start_b, start_c);
    check("tmo grant start_b", start_b, 1'b1);
    check("tmo grant start_c", start_c, 1'b1);
    @(posedge clk); #1;
    cu_b = 1'b0;
    seen = 1'b0;
    for (int i = 2; i <= 8; i++) begin
      @(posedge clk); #1;
      seen = seen | stop_b;
    end
    check("tmo early stop", seen, 1'b0);
    @(posedge clk); #1;
    $display("tmo fire stop_b=%b gnt_b=%b stop_c=%b", stop_b, gnt_b, stop_c);
    check("tmo fire stop_b", stop_b, 1'b1);
    check("tmo fire gnt_b", gnt_b, 4'b0001);
    check("tmo disabled stop_c", stop_c, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk); #1;
      seen = seen | stop_c;
    end
    $display("10000 cycles stop_c_seen=%b stop_b=%b", seen, stop_b);
    check("wd disabled 10000", seen, 1'b0);
    check("tmo stop held", stop_b, 1'b1);
    cu_b = 1'b1;
    @(posedge clk); #1;
    $display("tmo release done_b=%b tmo_b=%b done_c=%b tmo_c=%b", done_b, tmo_b, done_c, tmo_c);
    check("tmo release done_b", done_b, 4'b0001);
    check("tmo release tmo_b", tmo_b, 1'b1);
    check("tmo release stop_b", stop_b, 1'b0);
    check("tmo release gnt_b", gnt_b, 4'b0000);
    check("c release done_c", done_c, 4'b0001);
    check("c release tmo_c", tmo_c, 1'b0);
    req_b = 4'b0000;
    @(posedge clk); #1;
    check("tmo pulse width", {tmo_b, done_b}, 5'b0);

    // Timeout and cu_idle rise in the same RUN cycle: completion wins.
    req_b = 4'b0001; cu_b = 1'b1;
    @(posedge clk); #1;
    check("simul grant start_b", start_b, 1'b1);
    @(posedge clk); #1;
    cu_b = 1'b0;
    seen = 1'b0;
    for (int i = 2; i <= 8; i++) begin
      @(posedge clk); #1;
      seen = seen | stop_b;
    end
    cu_b = 1'b1;
    @(posedge clk); #1;
    seen = seen | stop_b;
    $display("simul release done_b=%b tmo_b=%b stop_seen=%b", done_b, tmo_b, seen);
    check("simul done_b", done_b, 4'b0001);
    check("simul tmo_b", tmo_b, 1'b0);
    check("simul no stop", seen, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
